// File: rtl/mem_ctrl_pkg.sv
// Shared types, default widths and a small helper for the memory port arbiter.
package mem_ctrl_pkg;

    // Default word-address and data widths of the instruction/data memory.
    localparam int unsigned DEF_ADDR_W = 30;
    localparam int unsigned DEF_DATA_W = 32;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        DONE
    } mem_state_t;

    // Identity of the granted requester.
    typedef enum logic {
        GNT_INSTR,
        GNT_DATA
    } grant_t;

    // The port that did not win last time; used to break ties.
    function automatic grant_t other_port(input grant_t g);
        return (g == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: bit 0 is the fetch port, bit 1 the data port.
// The grant is combinational; the last-grant history advances only when the
// consumer accepts a grant.
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output grant_t     gnt,
    output logic       any_req
);

    grant_t last_grant_q;

    assign any_req = |req;

    // Pick the single requester, or on a tie the one that did not win last.
    always_comb begin
        gnt = GNT_INSTR;
        case (req)
            2'b01:   gnt = GNT_INSTR;
            2'b10:   gnt = GNT_DATA;
            2'b11:   gnt = other_port(last_grant_q);
            default: gnt = GNT_INSTR;
        endcase
    end

    // Remember the most recent winner; reset to DATA so fetch wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_DATA;
        end else if (advance && any_req) begin
            last_grant_q <= gnt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master front end for a single-port synchronous memory with a one-cycle
// registered read. Fetch and data requests are arbitrated round-robin, the
// winning request is latched and issued to the memory port, and the result is
// returned to the winner with a single-cycle acknowledge.
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction fetch port (read only)
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    // Data load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // Memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    mem_state_t state_q;
    mem_state_t state_d;

    grant_t     gnt;
    grant_t     win_q;
    logic       any_req;
    logic       advance;
    logic       lat_we_q;
    logic [1:0] req_vec;

    assign req_vec = {d_req, i_req};

    // Requests are only looked at in IDLE; DONE deliberately ignores them so a
    // held request becomes a fresh transaction one cycle later.
    assign advance = (state_q == IDLE) && any_req;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (advance),
        .gnt     (gnt),
        .any_req (any_req)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: reads take an extra cycle for the registered memory output.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = lat_we_q ? DONE : RD_WAIT;
            RD_WAIT: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: write strobe in ISSUE, winner's ack in DONE.
    // Being purely state-decoded, both drop as soon as reset clears the state.
    always_comb begin
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        mem_wr_en = 1'b0;
        case (state_q)
            ISSUE: mem_wr_en = lat_we_q;
            DONE: begin
                if (win_q == GNT_INSTR) begin
                    i_ack = 1'b1;
                end else begin
                    d_ack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request latch: capture the winner's address, direction and store data.
    // mem_addr/mem_wdata are driven from these registers and hold between uses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q     <= GNT_INSTR;
            lat_we_q  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (advance) begin
            win_q <= gnt;
            if (gnt == GNT_DATA) begin
                mem_addr <= d_addr;
                lat_we_q <= d_we;
                if (d_we) begin
                    mem_wdata <= d_wdata;
                end
            end else begin
                mem_addr <= i_addr;
                lat_we_q <= 1'b0;
            end
        end
    end

    // Read-data capture: only the winner's register changes, and only for reads
    // (stores never pass through RD_WAIT).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (state_q == RD_WAIT) begin
            if (win_q == GNT_INSTR) begin
                i_rdata <= mem_rdata;
            end else begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule
